// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
//
// Writeback end of the pipeline. It selects the writeback result, writes it
// into an NREGS x DATA_W register file, and serves two decode read ports
// with write-first bypass. A per-register pending-write counter
// (scoreboard) tracks how many issued results have not yet come back, and
// decode is stalled on read-after-write hazards against those registers.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-low reset
//   RegWriteW   writeback write enable
//   MemtoRegW   1: ReadDataW, 0: ALUResultW
//   WriteRegW   writeback destination register
//   ReadDataW   memory load data
//   ALUResultW  ALU result
//   ResultW     selected writeback value (combinational)
//   RA1D/RA2D   decode read addresses
//   UseRA1D/2D  decode really consumes the matching read port
//   RD1D/RD2D   decode read data (combinational, bypassed)
//   IssueD      decode issues an instruction that writes IssueRegD
//   IssueRegD   destination of the issuing instruction
//   StallD      decode must hold; the issue is not accepted
//   ScoreErr    sticky scoreboard underflow/overflow flag
// -----------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int CNT_W  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       RegWriteW,
    input  logic                       MemtoRegW,
    input  logic [$clog2(NREGS)-1:0]   WriteRegW,
    input  logic [DATA_W-1:0]          ReadDataW,
    input  logic [DATA_W-1:0]          ALUResultW,
    output logic [DATA_W-1:0]          ResultW,
    input  logic [$clog2(NREGS)-1:0]   RA1D,
    input  logic [$clog2(NREGS)-1:0]   RA2D,
    input  logic                       UseRA1D,
    input  logic                       UseRA2D,
    output logic [DATA_W-1:0]          RD1D,
    output logic [DATA_W-1:0]          RD2D,
    input  logic                       IssueD,
    input  logic [$clog2(NREGS)-1:0]   IssueRegD,
    output logic                       StallD,
    output logic                       ScoreErr
);

    localparam int AW = $clog2(NREGS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Architectural state
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [CNT_W-1:0]  cnt_q  [NREGS];
    logic [CNT_W-1:0]  cnt_d  [NREGS];
    logic              score_err_q;
    logic              score_err_d;

    // Per-register hazard terms
    logic [NREGS-1:0]  retire_s;
    logic [NREGS-1:0]  busy_s;
    logic [NREGS-1:0]  inc_s;
    logic              stall_s;
    logic              accept_s;

    // Read-port value: R0 is hard zero, a same-cycle write to the address
    // wins over the stored value (write-first), otherwise the array entry.
    function automatic logic [DATA_W-1:0] read_sel(
        input logic [AW-1:0]     ra,
        input logic              wr_en,
        input logic [AW-1:0]     wa,
        input logic [DATA_W-1:0] wd,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] val;
        if (ra == '0) begin
            val = {DATA_W{1'b0}};
        end else if (wr_en && (wa == ra)) begin
            val = wd;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Writeback mux and the two bypassed decode read ports
    always_comb begin
        ResultW = MemtoRegW ? ReadDataW : ALUResultW;
        RD1D    = read_sel(RA1D, RegWriteW, WriteRegW, ResultW, regs_q[RA1D]);
        RD2D    = read_sel(RA2D, RegWriteW, WriteRegW, ResultW, regs_q[RA2D]);
    end

    // Scoreboard hazard detection: retire, busy, stall and issue acceptance
    always_comb begin
        retire_s = '0;
        busy_s   = '0;
        inc_s    = '0;
        for (int r = 0; r < NREGS; r++) begin
            // A write to R0 never retires anything; R0 is never tracked.
            retire_s[r] = RegWriteW && (WriteRegW == AW'(r)) && (WriteRegW != '0);
            // The last outstanding result arriving this cycle clears the
            // hazard immediately, so the consumer sees it through bypass.
            busy_s[r]   = (cnt_q[r] != '0) && !(retire_s[r] && (cnt_q[r] == CNT_ONE));
        end
        // A full counter blocks a new issue unless one slot frees up now.
        stall_s  = (UseRA1D && busy_s[RA1D])
                || (UseRA2D && busy_s[RA2D])
                || (IssueD && (cnt_q[IssueRegD] == CNT_MAX) && !retire_s[IssueRegD]);
        accept_s = IssueD && !stall_s && (IssueRegD != '0);
        for (int r = 0; r < NREGS; r++) begin
            inc_s[r] = accept_s && (IssueRegD == AW'(r));
        end
        StallD = stall_s;
    end

    // Next-state for register array, counters and the sticky error flag
    always_comb begin
        regs_d      = regs_q;
        cnt_d       = cnt_q;
        score_err_d = score_err_q;

        if (RegWriteW && (WriteRegW != '0)) begin
            regs_d[WriteRegW] = ResultW;
        end else begin
            regs_d[WriteRegW] = regs_q[WriteRegW];
        end

        for (int r = 0; r < NREGS; r++) begin
            case ({inc_s[r], retire_s[r]})
                2'b10: begin
                    // Saturate rather than wrap; only reachable if the
                    // stall is ignored upstream.
                    if (cnt_q[r] == CNT_MAX) begin
                        score_err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] + CNT_ONE;
                    end
                end
                2'b01: begin
                    // A result with nothing outstanding: counter stays 0.
                    if (cnt_q[r] == '0) begin
                        score_err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] - CNT_ONE;
                    end
                end
                default: begin
                    // Idle, or issue and retire cancelling each other.
                    cnt_d[r] = cnt_q[r];
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {DATA_W{1'b0}};
                cnt_q[r]  <= {CNT_W{1'b0}};
            end
            score_err_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            cnt_q       <= cnt_d;
            score_err_q <= score_err_d;
        end
    end

    assign ScoreErr = score_err_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW, MemtoRegW;
    logic [2:0]  WriteRegW;
    logic [15:0] ReadDataW, ALUResultW, ResultW;
    logic [2:0]  RA1D, RA2D;
    logic        UseRA1D, UseRA2D;
    logic [15:0] RD1D, RD2D;
    logic        IssueD;
    logic [2:0]  IssueRegD;
    logic        StallD, ScoreErr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .WriteRegW  (WriteRegW),
        .ReadDataW  (ReadDataW),
        .ALUResultW (ALUResultW),
        .ResultW    (ResultW),
        .RA1D       (RA1D),
        .RA2D       (RA2D),
        .UseRA1D    (UseRA1D),
        .UseRA2D    (UseRA2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .IssueD     (IssueD),
        .IssueRegD  (IssueRegD),
        .StallD     (StallD),
        .ScoreErr   (ScoreErr)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Move through one rising edge and land on the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 1'b1; RegWriteW = 1'b0; MemtoRegW = 1'b0; WriteRegW = 3'd0;
        ReadDataW = 16'h0000; ALUResultW = 16'h0000;
        RA1D = 3'd0; RA2D = 3'd0; UseRA1D = 1'b0; UseRA2D = 1'b0;
        IssueD = 1'b0; IssueRegD = 3'd0;
    endtask

    initial begin
        idle();
        @(negedge clk);
        // Reset overrides a simultaneous write and issue
        reset = 1'b0; RegWriteW = 1'b1; WriteRegW = 3'd3; ALUResultW = 16'h5555;
        IssueD = 1'b1; IssueRegD = 3'd3;
        step(); step();
        idle(); RA1D = 3'd3; UseRA1D = 1'b1;
        #1;
        chk("rst_rd1", RD1D, 16'h0000);
        chk("rst_stall", {15'd0, StallD}, 16'h0000);
        chk("rst_err", {15'd0, ScoreErr}, 16'h0000);
        step();

        // Writeback mux, bypass and array read
        idle(); IssueD = 1'b1; IssueRegD = 3'd2;
        #1 chk("iss2_stall", {15'd0, StallD}, 16'h0000);
        step();
        idle(); RegWriteW = 1'b1; MemtoRegW = 1'b1; ReadDataW = 16'hBEEF;
        ALUResultW = 16'h1234; WriteRegW = 3'd2; RA1D = 3'd2;
        #1;
        chk("mux_mem", ResultW, 16'hBEEF);
        chk("byp_mem", RD1D, 16'hBEEF);
        step();
        idle(); RA1D = 3'd2; IssueD = 1'b1; IssueRegD = 3'd2;
        #1;
        chk("arr_mem", RD1D, 16'hBEEF);
        chk("err_wb1", {15'd0, ScoreErr}, 16'h0000);
        step();
        idle(); RegWriteW = 1'b1; MemtoRegW = 1'b0; ReadDataW = 16'hBEEF;
        ALUResultW = 16'h1234; WriteRegW = 3'd2; RA1D = 3'd2;
        #1;
        chk("mux_alu", ResultW, 16'h1234);
        chk("byp_alu", RD1D, 16'h1234);
        step();
        idle(); RA1D = 3'd2;
        #1;
        chk("arr_alu", RD1D, 16'h1234);
        chk("err_wb2", {15'd0, ScoreErr}, 16'h0000);
        step();

        // R0: writes ignored, issue ignored
        idle(); RegWriteW = 1'b1; WriteRegW = 3'd0; ALUResultW = 16'hFFFF;
        RA2D = 3'd0; UseRA2D = 1'b1; IssueD = 1'b1; IssueRegD = 3'd0;
        #1;
        chk("r0_result", ResultW, 16'hFFFF);
        chk("r0_byp", RD2D, 16'h0000);
        chk("r0_iss_stall", {15'd0, StallD}, 16'h0000);
        step();
        idle(); RA2D = 3'd0; UseRA2D = 1'b1; RA1D = 3'd0; UseRA1D = 1'b1;
        #1;
        chk("r0_arr", RD2D, 16'h0000);
        chk("r0_cnt_stall", {15'd0, StallD}, 16'h0000);
        chk("r0_err", {15'd0, ScoreErr}, 16'h0000);
        step();

        // RAW stall on R5 until the result arrives
        idle(); IssueD = 1'b1; IssueRegD = 3'd5;
        #1 chk("iss5_stall", {15'd0, StallD}, 16'h0000);
        step();
        idle(); UseRA1D = 1'b1; RA1D = 3'd5;
        #1 chk("raw_stall1", {15'd0, StallD}, 16'h0001);
        step();
        #1 chk("raw_stall2", {15'd0, StallD}, 16'h0001);
        step();
        RegWriteW = 1'b1; WriteRegW = 3'd5; ALUResultW = 16'h00A5;
        #1;
        chk("raw_release", {15'd0, StallD}, 16'h0000);
        chk("raw_byp", RD1D, 16'h00A5);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("raw_after", {15'd0, StallD}, 16'h0000);
        chk("raw_arr", RD1D, 16'h00A5);
        step();

        // Simultaneous issue and retire on R4 keeps the count at 1
        idle(); IssueD = 1'b1; IssueRegD = 3'd4;
        step();
        RegWriteW = 1'b1; WriteRegW = 3'd4; ALUResultW = 16'h0444;
        #1 chk("r4_both_stall", {15'd0, StallD}, 16'h0000);
        step();
        idle(); UseRA1D = 1'b1; RA1D = 3'd4;
        #1;
        chk("r4_still_busy", {15'd0, StallD}, 16'h0001);
        chk("r4_arr1", RD1D, 16'h0444);
        step();
        RegWriteW = 1'b1; WriteRegW = 3'd4; ALUResultW = 16'h0777;
        #1;
        chk("r4_release", {15'd0, StallD}, 16'h0000);
        chk("r4_byp", RD1D, 16'h0777);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("r4_idle", {15'd0, StallD}, 16'h0000);
        chk("r4_arr2", RD1D, 16'h0777);
        chk("r4_err", {15'd0, ScoreErr}, 16'h0000);
        step();

        // Overflow: three issues to R6 accepted, fourth stalls
        idle(); IssueD = 1'b1; IssueRegD = 3'd6;
        for (int i = 0; i < 3; i++) begin
            #1 chk("r6_issue", {15'd0, StallD}, 16'h0000);
            step();
        end
        #1 chk("r6_full_stall", {15'd0, StallD}, 16'h0001);
        step();
        idle();
        #1 chk("r6_err", {15'd0, ScoreErr}, 16'h0000);
        // Drain: exactly three results must come back before R6 frees up
        RegWriteW = 1'b1; WriteRegW = 3'd6; ALUResultW = 16'h0600;
        UseRA1D = 1'b1; RA1D = 3'd6;
        #1 chk("r6_drain3", {15'd0, StallD}, 16'h0001);
        step();
        #1 chk("r6_drain2", {15'd0, StallD}, 16'h0001);
        step();
        #1 chk("r6_drain1", {15'd0, StallD}, 16'h0000);
        step();
        RegWriteW = 1'b0;
        #1;
        chk("r6_empty", {15'd0, StallD}, 16'h0000);
        chk("r6_err2", {15'd0, ScoreErr}, 16'h0000);
        step();

        // Underflow: retire to R7 with nothing pending
        idle(); RegWriteW = 1'b1; WriteRegW = 3'd7; ALUResultW = 16'h0007;
        #1 chk("uf_same_cycle", {15'd0, ScoreErr}, 16'h0000);
        step();
        idle();
        #1 chk("uf_set", {15'd0, ScoreErr}, 16'h0001);
        step(); step();
        #1 chk("uf_held", {15'd0, ScoreErr}, 16'h0001);
        reset = 1'b0;
        step();
        idle(); RA1D = 3'd6;
        #1;
        chk("uf_cleared", {15'd0, ScoreErr}, 16'h0000);
        chk("rst2_rd1", RD1D, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
